// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory controller: little-endian byte/half/word loads and stores
// over a 32-bit word array, with optional two-beat handling of word-crossing accesses.
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 32768,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic        r_unsigned;
  logic [1:0]  r_size;
  logic [31:0] r_lo;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic [29:0]      w_idx0;
  logic [30:0]      w_idx1;
  logic [4:0]       w_shift;
  logic             w_cross;
  logic             w_err;
  logic [7:0]       w_mask;
  logic [63:0]      w_wdata64;
  logic             w_inAcc2;
  logic [IDX_W-1:0] w_memIdx;
  logic [31:0]      w_memRd;
  logic [3:0]       w_lanes;
  logic [31:0]      w_wrWord;
  logic             w_memWe;
  logic [63:0]      w_raw;
  logic [31:0]      w_load;
  logic [31:0]      w_result;

  // Decode the captured request: lanes across a two-word window, crossing and error status.
  always_comb begin
    w_idx0    = r_addr[31:2];
    w_idx1    = {1'b0, w_idx0} + 31'd1;
    w_shift   = {r_addr[1:0], 3'b000};
    w_cross   = (r_size == 2'd1 && r_addr[1:0] == 2'd3) ||
                (r_size == 2'd2 && r_addr[1:0] != 2'd0);
    case (r_size)
      2'd0:    w_mask = 8'h01 << r_addr[1:0];
      2'd1:    w_mask = 8'h03 << r_addr[1:0];
      2'd2:    w_mask = 8'h0F << r_addr[1:0];
      default: w_mask = 8'h00;
    endcase
    w_err     = (r_size == 2'd3) ||
                ({2'b00, w_idx0} >= DEPTH_L) ||
                (w_cross && ({1'b0, w_idx1} >= DEPTH_L || !MISALIGN_EN));
    w_wdata64 = {32'h0, r_wdata} << w_shift;
  end

  // ACC1 works on the first word, ACC2 on the next one, through a single array port.
  always_comb begin
    w_inAcc2 = (r_state == ACC2);
    w_memIdx = w_inAcc2 ? w_idx1[IDX_W-1:0] : w_idx0[IDX_W-1:0];
    w_memRd  = r_mem[w_memIdx];
    w_lanes  = w_inAcc2 ? w_mask[7:4] : w_mask[3:0];
    w_wrWord = w_inAcc2 ? w_wdata64[63:32] : w_wdata64[31:0];
    w_memWe  = !rst && r_we && ((r_state == ACC1 && !w_err) || w_inAcc2);
  end

  always_ff @(posedge clk) begin
    if (w_memWe) begin
      for (int b = 0; b < 4; b++) begin
        if (w_lanes[b]) r_mem[w_memIdx][8*b +: 8] <= w_wrWord[8*b +: 8];
      end
    end
  end

  // Load assembly: realign the two-word window, then sign- or zero-extend.
  always_comb begin
    w_raw = {(w_inAcc2 ? w_memRd : 32'h0), (w_inAcc2 ? r_lo : w_memRd)} >> w_shift;
    case (r_size)
      2'd0:    w_load = r_unsigned ? {24'h0, w_raw[7:0]}  : {{24{w_raw[7]}}, w_raw[7:0]};
      2'd1:    w_load = r_unsigned ? {16'h0, w_raw[15:0]} : {{16{w_raw[15]}}, w_raw[15:0]};
      default: w_load = w_raw[31:0];
    endcase
    w_result = r_we ? 32'h0 : w_load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= 2'd0;
      r_lo       <= 32'h0;
      r_rdata    <= 32'h0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_we       <= req_we;
            r_unsigned <= req_unsigned;
            r_size     <= req_size;
            r_state    <= ACC1;
          end
        end
        ACC1: begin
          if (w_err) begin
            r_err   <= 1'b1;
            r_rdata <= 32'h0;
            r_state <= RESP;
          end else if (w_cross) begin
            r_lo    <= w_memRd;
            r_state <= ACC2;
          end else begin
            r_err   <= 1'b0;
            r_rdata <= w_result;
            r_state <= RESP;
          end
        end
        ACC2: begin
          r_err   <= 1'b0;
          r_rdata <= w_result;
          r_state <= RESP;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE) && !rst;
  assign rsp_valid = (r_state == RESP) && !rst;
  assign rsp_rdata = rst ? 32'h0 : r_rdata;
  assign rsp_err   = rst ? 1'b0 : r_err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one DUT with crossing support, one without,
// sharing the request inputs so each scenario exercises both behaviours.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        readyA, validA, errA, readyB, validB, errB;
  logic [31:0] rdataA, rdataB;

  int checks = 0;
  int errors = 0;
  logic [31:0] rA, rB;
  logic        eA, eB;
  int          lA, lB;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_WORDS(32768), .MISALIGN_EN(1'b1)) dutA (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(readyA), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(validA), .rsp_rdata(rdataA), .rsp_err(errA));

  data_mem_ctrl #(.DEPTH_WORDS(32768), .MISALIGN_EN(1'b0)) dutB (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(readyB), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(validB), .rsp_rdata(rdataB), .rsp_err(errB));

  // Issue one request to both DUTs and capture each response with its latency in cycles.
  task automatic doReq(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    n = 0;
    @(negedge clk);
    while (!(readyA && readyB) && n < 10) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lA = 0; lB = 0; rA = 'x; rB = 'x; eA = 1'bx; eB = 1'bx;
    for (int c = 1; c <= 8 && (lA == 0 || lB == 0); c++) begin
      @(negedge clk);
      if (validA && lA == 0) begin lA = c; rA = rdataA; eA = errA; end
      if (validB && lB == 0) begin lB = c; rB = rdataB; eB = errB; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({readyA, readyB} !== 2'b00) begin errors++; $display("[TB] FAIL rst_ready: got %b expected 00", {readyA, readyB}); end
    checks++; if ({validA, validB, errA, errB} !== 4'b0000) begin errors++; $display("[TB] FAIL rst_valid_err: got %b expected 0000", {validA, validB, errA, errB}); end
    checks++; if (rdataA !== 32'h0) begin errors++; $display("[TB] FAIL rst_rdata: got %h expected 00000000", rdataA); end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if ({readyA, readyB} !== 2'b11) begin errors++; $display("[TB] FAIL rst_release_ready: got %b expected 11", {readyA, readyB}); end
  endtask

  task automatic test_word_access;
    doReq(1'b1, 2'd2, 1'b0, 32'h100, 32'h11223344);
    checks++; if (lA !== 2 || rA !== 32'h0 || eA !== 1'b0) begin errors++; $display("[TB] FAIL sw_100: got lat=%0d rd=%h err=%b expected lat=2 rd=0 err=0", lA, rA, eA); end
    doReq(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    checks++; if (lA !== 2 || rA !== 32'h11223344 || eA !== 1'b0) begin errors++; $display("[TB] FAIL lw_100: got lat=%0d rd=%h err=%b expected lat=2 rd=11223344 err=0", lA, rA, eA); end
    repeat (3) @(negedge clk);
    checks++; if (rdataA !== 32'h11223344 || validA !== 1'b0) begin errors++; $display("[TB] FAIL rdata_hold: got rd=%h v=%b expected rd=11223344 v=0", rdataA, validA); end
    doReq(1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
    checks++; if (rA !== 32'h00000011) begin errors++; $display("[TB] FAIL lb_103: got %h expected 00000011", rA); end
    doReq(1'b0, 2'd1, 1'b0, 32'h102, 32'h0);
    checks++; if (rA !== 32'h00001122 || rB !== 32'h00001122) begin errors++; $display("[TB] FAIL lh_102: got A=%h B=%h expected 00001122", rA, rB); end
  endtask

  task automatic test_byte_sign;
    doReq(1'b1, 2'd2, 1'b0, 32'h200, 32'h55667788);
    doReq(1'b1, 2'd0, 1'b0, 32'h201, 32'hFFFFFF80);
    checks++; if (lA !== 2 || rA !== 32'h0) begin errors++; $display("[TB] FAIL sb_201: got lat=%0d rd=%h expected lat=2 rd=0", lA, rA); end
    doReq(1'b0, 2'd0, 1'b0, 32'h201, 32'h0);
    checks++; if (rA !== 32'hFFFFFF80) begin errors++; $display("[TB] FAIL lb_201: got %h expected ffffff80", rA); end
    doReq(1'b0, 2'd0, 1'b1, 32'h201, 32'h0);
    checks++; if (rA !== 32'h00000080) begin errors++; $display("[TB] FAIL lbu_201: got %h expected 00000080", rA); end
    doReq(1'b0, 2'd2, 1'b1, 32'h200, 32'h0);
    checks++; if (rA !== 32'h55668088 || rB !== 32'h55668088) begin errors++; $display("[TB] FAIL lw_200_lanes: got A=%h B=%h expected 55668088", rA, rB); end
    doReq(1'b0, 2'd1, 1'b1, 32'h200, 32'h0);
    checks++; if (rA !== 32'h00008088) begin errors++; $display("[TB] FAIL lhu_200: got %h expected 00008088", rA); end
  endtask

  task automatic test_back_to_back;
    doReq(1'b1, 2'd2, 1'b0, 32'h500, 32'hCAFEF00D);
    doReq(1'b0, 2'd2, 1'b0, 32'h500, 32'h0);
    checks++; if (lA !== 2 || rA !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL b2b_load: got lat=%0d rd=%h expected lat=2 rd=cafef00d", lA, rA); end
  endtask

  task automatic test_misaligned;
    doReq(1'b1, 2'd2, 1'b0, 32'h300, 32'h0);
    doReq(1'b1, 2'd2, 1'b0, 32'h304, 32'h0);
    doReq(1'b1, 2'd2, 1'b0, 32'h303, 32'hAABBCCDD);
    checks++; if (lA !== 3 || rA !== 32'h0 || eA !== 1'b0) begin errors++; $display("[TB] FAIL sw_303_a: got lat=%0d rd=%h err=%b expected lat=3 rd=0 err=0", lA, rA, eA); end
    checks++; if (lB !== 2 || rB !== 32'h0 || eB !== 1'b1) begin errors++; $display("[TB] FAIL sw_303_b: got lat=%0d rd=%h err=%b expected lat=2 rd=0 err=1", lB, rB, eB); end
    doReq(1'b0, 2'd2, 1'b0, 32'h303, 32'h0);
    checks++; if (lA !== 3 || rA !== 32'hAABBCCDD) begin errors++; $display("[TB] FAIL lw_303: got lat=%0d rd=%h expected lat=3 rd=aabbccdd", lA, rA); end
    doReq(1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
    checks++; if (rA !== 32'hDD000000 || rB !== 32'h0) begin errors++; $display("[TB] FAIL lw_300: got A=%h B=%h expected A=dd000000 B=00000000", rA, rB); end
    doReq(1'b0, 2'd2, 1'b0, 32'h304, 32'h0);
    checks++; if (rA !== 32'h00AABBCC || rB !== 32'h0) begin errors++; $display("[TB] FAIL lw_304: got A=%h B=%h expected A=00aabbcc B=00000000", rA, rB); end
    doReq(1'b0, 2'd1, 1'b0, 32'h303, 32'h0);
    checks++; if (lA !== 3 || rA !== 32'hFFFFCCDD) begin errors++; $display("[TB] FAIL lh_303: got lat=%0d rd=%h expected lat=3 rd=ffffccdd", lA, rA); end
  endtask

  task automatic test_misalign_disabled;
    doReq(1'b1, 2'd2, 1'b0, 32'h104, 32'h0);
    doReq(1'b0, 2'd1, 1'b0, 32'h103, 32'h0);
    checks++; if (lB !== 2 || eB !== 1'b1 || rB !== 32'h0) begin errors++; $display("[TB] FAIL lh_103_b: got lat=%0d err=%b rd=%h expected lat=2 err=1 rd=0", lB, eB, rB); end
    checks++; if (lA !== 3 || eA !== 1'b0 || rA !== 32'h00000011) begin errors++; $display("[TB] FAIL lh_103_a: got lat=%0d err=%b rd=%h expected lat=3 err=0 rd=00000011", lA, eA, rA); end
    doReq(1'b1, 2'd1, 1'b0, 32'h103, 32'h0000BEEF);
    checks++; if (eB !== 1'b1 || eA !== 1'b0) begin errors++; $display("[TB] FAIL sh_103: got errA=%b errB=%b expected errA=0 errB=1", eA, eB); end
    doReq(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    checks++; if (rB !== 32'h11223344 || rA !== 32'hEF223344) begin errors++; $display("[TB] FAIL lw_100_after: got A=%h B=%h expected A=ef223344 B=11223344", rA, rB); end
    doReq(1'b0, 2'd2, 1'b0, 32'h104, 32'h0);
    checks++; if (rB !== 32'h0 || rA !== 32'h000000BE) begin errors++; $display("[TB] FAIL lw_104_after: got A=%h B=%h expected A=000000be B=00000000", rA, rB); end
  endtask

  task automatic test_errors;
    doReq(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
    checks++; if (lA !== 2 || eA !== 1'b1 || rA !== 32'h0 || eB !== 1'b1) begin errors++; $display("[TB] FAIL size3: got lat=%0d errA=%b rd=%h errB=%b expected lat=2 1 0 1", lA, eA, rA, eB); end
    doReq(1'b0, 2'd2, 1'b0, 32'h00020000, 32'h0);
    checks++; if (eA !== 1'b1 || rA !== 32'h0 || eB !== 1'b1) begin errors++; $display("[TB] FAIL addr_oob: got errA=%b rd=%h errB=%b expected 1 0 1", eA, rA, eB); end
    doReq(1'b1, 2'd2, 1'b0, 32'h0001FFFC, 32'h0);
    checks++; if (eA !== 1'b0 || eB !== 1'b0) begin errors++; $display("[TB] FAIL last_word_ok: got errA=%b errB=%b expected 0 0", eA, eB); end
    doReq(1'b1, 2'd2, 1'b0, 32'h0001FFFE, 32'hDEADBEEF);
    checks++; if (lA !== 2 || eA !== 1'b1 || eB !== 1'b1) begin errors++; $display("[TB] FAIL cross_oob: got lat=%0d errA=%b errB=%b expected lat=2 1 1", lA, eA, eB); end
    doReq(1'b0, 2'd2, 1'b0, 32'h0001FFFC, 32'h0);
    checks++; if (rA !== 32'h0 || rB !== 32'h0) begin errors++; $display("[TB] FAIL cross_oob_nowrite: got A=%h B=%h expected 00000000", rA, rB); end
  endtask

  task automatic test_reset_abort;
    int pulses;
    doReq(1'b1, 2'd2, 1'b0, 32'h400, 32'h0);
    doReq(1'b1, 2'd2, 1'b0, 32'h404, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h402; req_wdata = 32'h12345678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++; if ({validA, validB, readyA} !== 3'b000 || rdataB !== 32'h0) begin errors++; $display("[TB] FAIL abort_in_rst: got vA,vB,rdyA=%b rdB=%h expected 000 0", {validA, validB, readyA}, rdataB); end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if ({readyA, readyB} !== 2'b11) begin errors++; $display("[TB] FAIL abort_ready: got %b expected 11", {readyA, readyB}); end
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (validA || validB) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL abort_no_rsp: got %0d pulses expected 0", pulses); end
    doReq(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
    checks++; if (rA !== 32'h56780000 || rB !== 32'h0) begin errors++; $display("[TB] FAIL abort_first_word: got A=%h B=%h expected A=56780000 B=00000000", rA, rB); end
    doReq(1'b0, 2'd2, 1'b0, 32'h404, 32'h0);
    checks++; if (rA !== 32'h0 || rB !== 32'h0) begin errors++; $display("[TB] FAIL abort_second_word: got A=%h B=%h expected 00000000", rA, rB); end
  endtask

  initial begin
    test_reset();
    test_word_access();
    test_byte_sign();
    test_back_to_back();
    test_misaligned();
    test_misalign_disabled();
    test_errors();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DEPTH_WORDS, 32768, number of 32-bit words in the array.
- MISALIGN_EN, 1, 1 = word-crossing accesses split into two beats; 0 = crossing accesses return an error.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on the rising edge.
- rst, in, 1, synchronous, active-high reset.
- req_valid, in, 1, request present.
- req_ready, out, 1, controller can accept a request.
- req_we, in, 1, 1 = store, 0 = load.
- req_size, in, 2, access size: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned, in, 1, zero-extend a byte or half load.
- req_addr, in, 32, byte address.
- req_wdata, in, 32, store data, right-aligned.
- rsp_valid, out, 1, one-cycle response pulse.
- rsp_rdata, out, 32, load result.
- rsp_err, out, 1, request rejected.

REQ-003 The block SHALL use one clock (clk) and a synchronous, active-high reset (rst).

Function
REQ-004 A request SHALL be accepted on a rising edge where req_valid && req_ready; req_addr, req_we, req_size, req_unsigned and req_wdata SHALL be captured at that edge.
REQ-005 States SHALL be IDLE, ACC1, ACC2, RESP; req_ready SHALL be 1 only in IDLE.
REQ-006 State transitions SHALL be:
- IDLE -> ACC1 on accept.
- ACC1 -> ACC2 if the access crosses a word and is legal; otherwise ACC1 -> RESP.
- ACC2 -> RESP.
- RESP -> IDLE.
REQ-007 Byte order SHALL be little-endian: byte address k maps to lane k%4 of word k>>2.
REQ-008 Word-crossing SHALL be defined as: half with addr[1:0]==3, or word with addr[1:0]!=0; byte accesses never cross.
REQ-009 ACC1 SHALL access word addr>>2; ACC2 SHALL access word (addr>>2)+1, with the remaining high-order bytes in the low lanes.
REQ-010 Stores SHALL write only the addressed byte lanes; all other lanes SHALL be unchanged.
REQ-011 Load result assembly:
- Byte and half loads are sign-extended from their top bit unless req_unsigned=1, in which case they are zero-extended.
- Word loads ignore req_unsigned.
REQ-012 Error conditions SHALL be: req_size==3; any touched word index >= DEPTH_WORDS; crossing access with MISALIGN_EN=0.
REQ-013 Error handling: no memory write SHALL occur and the FSM SHALL go ACC1 -> RESP with rsp_err=1 and rsp_rdata=0.
REQ-014 rsp_valid SHALL be high exactly during the RESP cycle.
- Latency: accept in cycle N gives rsp_valid in cycle N+2 (non-crossing or error) or N+3 (crossing).
REQ-015 On a store response, rsp_rdata SHALL be 0.
REQ-016 rsp_rdata and rsp_err SHALL be registered and SHALL hold their values until the next RESP.
REQ-017 There SHALL be no response backpressure, and at most one request SHALL be outstanding.
REQ-018 A load issued in the IDLE cycle following a store's RESP SHALL return the newly stored data.
REQ-019 Array contents SHALL not be initialised or cleared by rst.

Reset
REQ-020 While rst=1:
- state is IDLE;
- req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
req_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-021 Reset in ACC1, ACC2 or RESP SHALL abort the operation:
- no response is produced;
- a crossing store reset in ACC2 SHALL leave the ACC1 lanes written and the ACC2 lanes unwritten;
- the request SHALL not be replayed.

Verification
REQ-022 Store word 0x11223344 @0x100, then load word @0x100 -> rsp_rdata=0x11223344; loads LB @0x103 -> 0x00000011; LH @0x102 -> 0x00001122.
REQ-023 Store byte 0x80 @0x201, then:
- LB @0x201 -> 0xFFFFFF80;
- LBU @0x201 -> 0x00000080;
- other lanes of word 0x200 unchanged.
REQ-024 MISALIGN_EN=1: store word 0xAABBCCDD @0x303 -> rsp_valid in cycle N+3; load word @0x303 -> 0xAABBCCDD; word 0x300 lane3=0xDD; word 0x304 lanes0..2=0xCC,0xBB,0xAA.
REQ-025 MISALIGN_EN=0: load half @0x103 -> rsp_err=1, rsp_rdata=0, cycle N+2; a following store to 0x103 is rejected with memory unchanged.
REQ-026 Errors: req_size=3 -> rsp_err=1; address (DEPTH_WORDS*4) -> rsp_err=1; word @(DEPTH_WORDS*4-2) with MISALIGN_EN=1 -> rsp_err=1, no lanes written.
REQ-027 Assert rst during ACC2 of a crossing store -> no rsp_valid; req_ready=1 in the cycle after rst deasserts; first-word lanes written, second-word lanes untouched.
